// File: rtl/qspi_request_queue.sv
// Host-side request queue for the QSPI shifter: buffers read/write requests in a FIFO and
// issues them one at a time over level-sensitive strobes, returning one in-order response each.
module qspi_request_queue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic        o_rsp_write,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_sh_we,
    output logic        o_sh_re,
    output logic [31:0] o_sh_address,
    output logic [31:0] o_sh_data_in,
    input  logic        i_sh_cs_n,
    input  logic [31:0] i_sh_data_out
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StBusy,
        StResp
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic          r_mem_write [DEPTH];
    logic [31:0]   r_mem_addr  [DEPTH];
    logic [31:0]   r_mem_wdata [DEPTH];

    logic          r_cmd_write;
    logic [31:0]   r_cmd_addr;
    logic [31:0]   r_cmd_wdata;

    logic [CW-1:0] r_tmo;
    logic [CW-1:0] w_tmo_next;

    logic          r_sh_we;
    logic          r_sh_re;
    logic [31:0]   r_sh_address;
    logic [31:0]   r_sh_data_in;
    logic          w_sh_we_next;
    logic          w_sh_re_next;
    logic [31:0]   w_sh_address_next;
    logic [31:0]   w_sh_data_in_next;

    logic          r_rsp_valid;
    logic          r_rsp_write;
    logic [31:0]   r_rsp_rdata;
    logic          r_rsp_err;
    logic          w_rsp_valid_next;
    logic          w_rsp_write_next;
    logic [31:0]   w_rsp_rdata_next;
    logic          w_rsp_err_next;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    // Ready depends only on the registered count, so a full FIFO refuses even while popping.
    assign w_full      = (r_count == (AW + 1)'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign o_req_ready = !w_full;
    assign w_push      = i_req_valid && !w_full;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_write[r_wr_ptr] <= i_req_write;
            r_mem_addr[r_wr_ptr]  <= i_req_addr;
            r_mem_wdata[r_wr_ptr] <= i_req_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW + 1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cmd_write <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
        end else if (w_pop) begin
            r_cmd_write <= r_mem_write[r_rd_ptr];
            r_cmd_addr  <= r_mem_addr[r_rd_ptr];
            r_cmd_wdata <= r_mem_wdata[r_rd_ptr];
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= StIdle;
            r_tmo        <= '0;
            r_sh_we      <= 1'b0;
            r_sh_re      <= 1'b0;
            r_sh_address <= '0;
            r_sh_data_in <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_write  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_tmo        <= w_tmo_next;
            r_sh_we      <= w_sh_we_next;
            r_sh_re      <= w_sh_re_next;
            r_sh_address <= w_sh_address_next;
            r_sh_data_in <= w_sh_data_in_next;
            r_rsp_valid  <= w_rsp_valid_next;
            r_rsp_write  <= w_rsp_write_next;
            r_rsp_rdata  <= w_rsp_rdata_next;
            r_rsp_err    <= w_rsp_err_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_pop             = 1'b0;
        w_tmo_next        = r_tmo;
        w_sh_we_next      = r_sh_we;
        w_sh_re_next      = r_sh_re;
        w_sh_address_next = r_sh_address;
        w_sh_data_in_next = r_sh_data_in;
        w_rsp_valid_next  = r_rsp_valid;
        w_rsp_write_next  = r_rsp_write;
        w_rsp_rdata_next  = r_rsp_rdata;
        w_rsp_err_next    = r_rsp_err;

        unique case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_tmo_next   = '0;
                    w_state_next = StIssue;
                end
            end
            StIssue: begin
                w_sh_we_next      = r_cmd_write;
                w_sh_re_next      = !r_cmd_write;
                w_sh_address_next = r_cmd_addr;
                w_sh_data_in_next = r_cmd_wdata;
                if (!i_sh_cs_n) begin
                    w_state_next = StBusy;
                end else if (r_tmo == CW'(TIMEOUT)) begin
                    w_sh_we_next     = 1'b0;
                    w_sh_re_next     = 1'b0;
                    w_rsp_valid_next = 1'b1;
                    w_rsp_write_next = r_cmd_write;
                    w_rsp_rdata_next = '0;
                    w_rsp_err_next   = 1'b1;
                    w_state_next     = StResp;
                end else begin
                    w_tmo_next = r_tmo + CW'(1);
                end
            end
            StBusy: begin
                // First high sample of cs_n ends the transaction; no timeout here.
                if (i_sh_cs_n) begin
                    w_sh_we_next     = 1'b0;
                    w_sh_re_next     = 1'b0;
                    w_rsp_valid_next = 1'b1;
                    w_rsp_write_next = r_cmd_write;
                    w_rsp_rdata_next = r_cmd_write ? 32'h0 : i_sh_data_out;
                    w_rsp_err_next   = 1'b0;
                    w_state_next     = StResp;
                end
            end
            StResp: begin
                if (i_rsp_ready) begin
                    w_rsp_valid_next = 1'b0;
                    w_state_next     = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_write  = r_rsp_write;
    assign o_rsp_rdata  = r_rsp_rdata;
    assign o_rsp_err    = r_rsp_err;
    assign o_sh_we      = r_sh_we;
    assign o_sh_re      = r_sh_re;
    assign o_sh_address = r_sh_address;
    assign o_sh_data_in = r_sh_data_in;

endmodule

// File: tb/tb_qspi_request_queue.sv
// Bench for qspi_request_queue: directed scenarios plus randomized traffic scored against an
// in-order request/response model and a behavioural shifter.
module tb_qspi_request_queue;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 10;

    typedef struct packed {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic        e;
    } req_t;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        sh_we;
    logic        sh_re;
    logic [31:0] sh_address;
    logic [31:0] sh_data_in;
    logic        sh_cs_n;
    logic [31:0] sh_data_out;

    int   checks = 0;
    int   failures = 0;
    int   n_rsp = 0;
    int   both_high = 0;
    req_t exp_q[$];
    req_t iss_q[$];
    logic exp_err_next = 1'b0;
    logic sh_enable = 1'b1;
    logic sh_random = 1'b0;
    logic [31:0] last_rdata = 32'h0;

    qspi_request_queue #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_write   (req_write),
        .i_req_addr    (req_addr),
        .i_req_wdata   (req_wdata),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_write   (rsp_write),
        .o_rsp_rdata   (rsp_rdata),
        .o_rsp_err     (rsp_err),
        .o_sh_we       (sh_we),
        .o_sh_re       (sh_re),
        .o_sh_address  (sh_address),
        .o_sh_data_in  (sh_data_in),
        .i_sh_cs_n     (sh_cs_n),
        .i_sh_data_out (sh_data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Shifter memory contents as seen by reads.
    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        if (a == 32'd111) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5AA5A5;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic w, input logic [31:0] a, input logic [31:0] d);
        logic rdy;
        int   n;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        rdy = 1'b0;
        for (n = 0; n < 200 && !rdy; n++) begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk);
            #1;
        end
        if (!rdy) chk1("push_timeout", req_ready, 1'b1);
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            cyc();
            n++;
        end
        chk32("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    // Model of accepted requests: every handshake enters both the response and issue queues.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && req_valid && req_ready) begin
                req_t r;
                r.w = req_write;
                r.a = req_addr;
                r.d = req_wdata;
                r.e = exp_err_next;
                exp_q.push_back(r);
                iss_q.push_back(r);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && rsp_valid && rsp_ready) begin
                chk1("rsp_strobes_low", sh_we | sh_re, 1'b0);
                if (exp_q.size() == 0) begin
                    chk1("unexpected_rsp", rsp_valid, 1'b0);
                end else begin
                    req_t e;
                    e = exp_q.pop_front();
                    chk1("rsp_write", rsp_write, e.w);
                    chk1("rsp_err", rsp_err, e.e);
                    chk32("rsp_rdata", rsp_rdata, (e.w || e.e) ? 32'h0 : rd_fn(e.a));
                    last_rdata = rsp_rdata;
                    n_rsp++;
                end
            end
        end
    end

    initial begin
        logic prev_strobe;
        prev_strobe = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_strobe = 1'b0;
            end else begin
                if (sh_we && sh_re) both_high++;
                if ((sh_we || sh_re) && !prev_strobe) begin
                    if (iss_q.size() == 0) begin
                        chk1("unexpected_issue", sh_we | sh_re, 1'b0);
                    end else begin
                        req_t e;
                        e = iss_q.pop_front();
                        chk1("issue_we", sh_we, e.w);
                        chk1("issue_re", sh_re, !e.w);
                        chk32("issue_addr", sh_address, e.a);
                        if (e.w) chk32("issue_wdata", sh_data_in, e.d);
                    end
                end
                prev_strobe = sh_we || sh_re;
            end
        end
    end

    // Shifter: on a new strobe, wait a delay, hold cs_n low, then release and await strobe drop.
    initial begin
        int   st;
        int   cnt;
        logic prev;
        st = 0;
        cnt = 0;
        prev = 1'b0;
        sh_cs_n = 1'b1;
        sh_data_out = 32'h0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                st = 0;
                sh_cs_n = 1'b1;
                prev = 1'b0;
            end else begin
                case (st)
                    0: if ((sh_we || sh_re) && !prev && sh_enable) begin
                        cnt = sh_random ? int'($urandom_range(1, 5)) : 3;
                        st = 1;
                    end
                    1: begin
                        cnt--;
                        if (cnt == 0) begin
                            sh_cs_n = 1'b0;
                            sh_data_out = sh_re ? rd_fn(sh_address) : $urandom;
                            cnt = sh_random ? int'($urandom_range(1, 6)) : 20;
                            st = 2;
                        end
                    end
                    2: begin
                        cnt--;
                        if (cnt == 0) begin
                            sh_cs_n = 1'b1;
                            st = 3;
                        end
                    end
                    default: if (!(sh_we || sh_re)) st = 0;
                endcase
                prev = sh_we || sh_re;
            end
        end
    end

    initial begin
        int   cnt;
        logic acc;
        logic seen;
        int   sent;
        int   guard;

        reset_n = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        rsp_ready = 1'b0;
        #1;
        chk1("rst_req_ready", req_ready, 1'b1);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_rsp_write", rsp_write, 1'b0);
        chk1("rst_rsp_err", rsp_err, 1'b0);
        chk1("rst_sh_we", sh_we, 1'b0);
        chk1("rst_sh_re", sh_re, 1'b0);
        chk32("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk32("rst_sh_address", sh_address, 32'h0);
        chk32("rst_sh_data_in", sh_data_in, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc();
        chk1("post_rst_ready", req_ready, 1'b1);
        chk1("post_rst_rsp_valid", rsp_valid, 1'b0);

        // Single read with issue latency.
        push_req(1'b0, 32'd111, 32'h0);
        req_valid = 1'b0;
        chk1("lat_edge_n", sh_re, 1'b0);
        cyc();
        chk1("lat_edge_n1", sh_re, 1'b0);
        cyc();
        chk1("lat_edge_n2_re", sh_re, 1'b1);
        chk1("lat_edge_n2_we", sh_we, 1'b0);
        chk32("single_addr", sh_address, 32'd111);
        rsp_ready = 1'b1;
        drain(100);
        chk32("single_rdata", last_rdata, 32'hDEADBEEF);
        chk32("single_count", 32'(n_rsp), 32'd1);

        // Back-to-back: five pushes, FIFO fills to DEPTH behind the first.
        rsp_ready = 1'b0;
        push_req(1'b1, 32'd333, 32'd100);
        push_req(1'b0, 32'd1, 32'h0);
        push_req(1'b0, 32'd2, 32'h0);
        push_req(1'b0, 32'd3, 32'h0);
        push_req(1'b0, 32'd4, 32'h0);
        req_valid = 1'b0;
        chk1("b2b_full_ready", req_ready, 1'b0);
        rsp_ready = 1'b1;
        drain(600);
        chk32("b2b_count", 32'(n_rsp), 32'd6);

        // Timeout: shifter ignores the first strobe; the queued write then completes.
        rsp_ready = 1'b0;
        sh_enable = 1'b0;
        exp_err_next = 1'b1;
        push_req(1'b0, 32'h55, 32'h0);
        exp_err_next = 1'b0;
        push_req(1'b1, 32'h77, 32'h1234_5678);
        req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = sh_we || sh_re;
        end
        chk1("tmo_strobe_seen", sh_we | sh_re, 1'b1);
        cnt = 0;
        do begin
            cnt++;
            @(negedge clk);
        end while ((sh_we || sh_re) && cnt < 50);
        chk32("tmo_strobe_cycles", 32'(cnt), 32'(TIMEOUT));
        chk1("tmo_rsp_valid", rsp_valid, 1'b1);
        chk1("tmo_rsp_err", rsp_err, 1'b1);
        chk32("tmo_rsp_rdata", rsp_rdata, 32'h0);
        sh_enable = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        drain(200);

        // Response backpressure for 8 cycles while the queue fills.
        rsp_ready = 1'b0;
        push_req(1'b0, 32'h200, 32'h0);
        req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        chk1("bp_rsp_valid", rsp_valid, 1'b1);
        @(posedge clk);
        #1;
        req_write = 1'($urandom);
        req_addr = $urandom;
        req_wdata = $urandom;
        req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            acc = req_valid && req_ready;
            chk1("bp_hold_valid", rsp_valid, 1'b1);
            chk32("bp_hold_rdata", rsp_rdata, rd_fn(32'h200));
            chk1("bp_no_strobe", sh_we | sh_re, 1'b0);
            @(posedge clk);
            #1;
            if (acc) begin
                req_write = 1'($urandom);
                req_addr = $urandom;
                req_wdata = $urandom;
            end
        end
        req_valid = 1'b0;
        chk1("bp_full_ready", req_ready, 1'b0);
        chk32("bp_queued", 32'(exp_q.size()), 32'd5);
        rsp_ready = 1'b1;
        cyc();
        chk1("ready_before_pop", req_ready, 1'b0);
        cyc();
        chk1("ready_after_pop", req_ready, 1'b1);
        drain(800);

        // Randomized traffic with random shifter timing and response backpressure.
        sh_random = 1'b1;
        sent = 0;
        guard = 0;
        while ((sent < 40 || req_valid) && guard < 6000) begin
            @(negedge clk);
            acc = req_valid && req_ready;
            @(posedge clk);
            #1;
            guard++;
            if (acc) req_valid = 1'b0;
            if (!req_valid && sent < 40 && $urandom_range(0, 2) != 0) begin
                req_write = 1'($urandom);
                req_addr = $urandom;
                req_wdata = $urandom;
                req_valid = 1'b1;
                sent++;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid = 1'b0;
        chk1("rand_all_sent", req_valid, 1'b0);
        rsp_ready = 1'b1;
        drain(2000);

        // Reset in the middle of a BUSY transaction with more requests queued.
        sh_random = 1'b0;
        push_req(1'b0, 32'h300, 32'h0);
        push_req(1'b0, 32'h301, 32'h0);
        push_req(1'b1, 32'h302, 32'hCAFE_F00D);
        req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = !sh_cs_n;
        end
        chk1("mid_busy_strobe", sh_re, 1'b1);
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk1("mid_rst_re", sh_re, 1'b0);
        chk1("mid_rst_we", sh_we, 1'b0);
        chk1("mid_rst_rsp_valid", rsp_valid, 1'b0);
        chk1("mid_rst_ready", req_ready, 1'b1);
        exp_q.delete();
        iss_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk1("post_mid_no_strobe", sh_we | sh_re, 1'b0);
            chk1("post_mid_no_rsp", rsp_valid, 1'b0);
        end
        chk1("post_mid_ready", req_ready, 1'b1);

        chk32("never_both_strobes", 32'(both_high), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
